// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N byte-stream
// requesters. A grant is held for a whole message: it ends on the byte
// flagged last, or when the owner leaves vld low for TIMEOUT cycles.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no owner; all outputs low; pick next requester from ptr_q
//   S_OWN  | owner_q drives the transmitter through a zero-latency path
module uart_tx_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*8-1:0] i_req_data,
  input  logic [N-1:0]   i_req_vld,
  input  logic [N-1:0]   i_req_last,
  output logic [N-1:0]   o_req_rdy,
  output logic [7:0]     o_tx_data,
  output logic           o_tx_vld,
  input  logic           i_tx_rdy,
  output logic [N-1:0]   o_grant,
  output logic           o_busy
);

  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;
  // A zero TIMEOUT would give a zero-width counter; keep one bit that never moves.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;

  logic            scan_hit;
  logic [IW-1:0]   scan_idx;
  logic [SW-1:0]   scan_sum;
  logic [IW-1:0]   owner_inc;
  logic            owner_vld;
  logic            owner_last;

  // Find the first requesting index at or after ptr_q, wrapping at N.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    scan_sum = '0;
    for (int i = 0; i < N; i++) begin
      scan_sum = {1'b0, ptr_q} + SW'(i);
      if (scan_sum >= SW'(N)) begin
        scan_sum = scan_sum - SW'(N);
      end
      if (!scan_hit && i_req_vld[scan_sum[IW-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = scan_sum[IW-1:0];
      end
    end
  end

  // Owner-side views used by the FSM and the pass-through datapath.
  always_comb begin
    owner_vld  = i_req_vld[owner_q];
    owner_last = i_req_last[owner_q];
    owner_inc  = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
  end

  // Next-state logic, release/timeout handling and output decode.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    idle_cnt_d = idle_cnt_q;
    o_req_rdy  = '0;
    o_tx_data  = '0;
    o_tx_vld   = 1'b0;
    o_grant    = '0;
    o_busy     = 1'b0;

    case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (scan_hit) begin
          owner_d = scan_idx;
          state_d = S_OWN;
        end
      end

      S_OWN: begin
        o_busy             = 1'b1;
        o_grant            = ONE_HOT0 << owner_q;
        o_tx_data          = i_req_data[{owner_q, 3'b000} +: 8];
        o_tx_vld           = owner_vld;
        o_req_rdy[owner_q] = i_tx_rdy;

        if (owner_vld) begin
          idle_cnt_d = '0;
          if (i_tx_rdy && owner_last) begin
            state_d = S_IDLE;
            ptr_d   = owner_inc;
          end
        end else if (TIMEOUT != 0) begin
          // Revocation is safe here: with vld low no byte is in flight.
          if (idle_cnt_q == CNT_LAST) begin
            state_d    = S_IDLE;
            ptr_d      = owner_inc;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-message abandons it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (N=4, TIMEOUT=4). Expected bytes and their
// owners are queued when stimulus is driven and popped as the DUT transfers.
module tb_uart_tx_arb;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] dat;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N*8-1:0] i_req_data;
  logic [N-1:0]   i_req_vld;
  logic [N-1:0]   i_req_last;
  logic [N-1:0]   o_req_rdy;
  logic [7:0]     o_tx_data;
  logic           o_tx_vld;
  logic           i_tx_rdy;
  logic [N-1:0]   o_grant;
  logic           o_busy;

  int   errors;
  int   checks;
  exp_t sb[$];

  uart_tx_arb #(.N(N), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req_data (i_req_data),
    .i_req_vld  (i_req_vld),
    .i_req_last (i_req_last),
    .o_req_rdy  (o_req_rdy),
    .o_tx_data  (o_tx_data),
    .o_tx_vld   (o_tx_vld),
    .i_tx_rdy   (i_tx_rdy),
    .o_grant    (o_grant),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int k, input logic vld, input logic [7:0] d, input logic last);
    i_req_vld[k]        = vld;
    i_req_data[k*8 +: 8] = d;
    i_req_last[k]       = last;
  endtask

  task automatic push(input int k, input logic [7:0] d);
    exp_t e;
    e.own = 2'(k);
    e.dat = d;
    sb.push_back(e);
  endtask

  // One clock: score any transfer at the falling edge, return just after the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (o_tx_vld && i_tx_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected observed=0x%0h expected=no_transfer", o_tx_data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", o_tx_data, e.dat);
        chk("sb_grant", o_grant, 32'(4'b0001 << e.own));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    i_req_data = '0;
    i_req_vld  = '0;
    i_req_last = '0;
    i_tx_rdy   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_grant", o_grant, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_tx_vld", o_tx_vld, 0);
    chk("rst_rdy", o_req_rdy, 0);
    chk("rst_tx_data", o_tx_data, 0);

    // Requester 0: three-byte message 0x41 0x42 0x43.
    drv(0, 1, 8'h41, 0); push(0, 8'h41); #1;
    chk("t1_idle_grant", o_grant, 0);
    chk("t1_idle_rdy", o_req_rdy, 0);
    cyc();
    chk("t1_grant", o_grant, 4'b0001);
    chk("t1_rdy", o_req_rdy, 4'b0001);
    cyc();
    drv(0, 1, 8'h42, 0); push(0, 8'h42); #1;
    chk("t1_busy", o_busy, 1);
    cyc();
    drv(0, 1, 8'h43, 1); push(0, 8'h43); #1;
    chk("t1_last_vld", o_tx_vld, 1);
    cyc();
    drv(0, 0, 8'h00, 0); #1;
    chk("t1_released_grant", o_grant, 0);
    chk("t1_released_busy", o_busy, 0);
    cyc();

    // Reset, then requesters 0 and 2 together, twice.
    rst = 1'b1; cyc(); rst = 1'b0;
    drv(0, 1, 8'hA0, 1); drv(2, 1, 8'hC0, 1); push(0, 8'hA0); push(2, 8'hC0); #1;
    cyc();
    chk("t2_first", o_grant, 4'b0001);
    cyc();
    drv(0, 0, 8'h00, 0); #1;
    chk("t2_dead", o_grant, 0);
    cyc();
    chk("t2_second", o_grant, 4'b0100);
    cyc();
    drv(2, 0, 8'h00, 0);
    drv(0, 1, 8'hA1, 1); drv(2, 1, 8'hC1, 1); push(0, 8'hA1); push(2, 8'hC1); #1;
    chk("t2_idle_before_repeat", o_busy, 0);
    cyc();
    chk("t2_rep_first", o_grant, 4'b0001);
    cyc();
    drv(0, 0, 8'h00, 0); #1;
    chk("t2_rep_dead", o_grant, 0);
    cyc();
    chk("t2_rep_second", o_grant, 4'b0100);
    cyc();
    drv(2, 0, 8'h00, 0); #1;

    // Requester 1 owns; requester 3 arrives mid-message.
    drv(1, 1, 8'h11, 0); push(1, 8'h11); #1;
    cyc();
    chk("t3_grant1", o_grant, 4'b0010);
    cyc();
    drv(1, 1, 8'h12, 0); push(1, 8'h12); drv(3, 1, 8'h33, 1); #1;
    chk("t3_rdy_mid", o_req_rdy, 4'b0010);
    cyc();
    drv(1, 1, 8'h13, 1); push(1, 8'h13); push(3, 8'h33); #1;
    chk("t3_rdy_last", o_req_rdy, 4'b0010);
    chk("t3_grant_last", o_grant, 4'b0010);
    cyc();
    drv(1, 0, 8'h00, 0); #1;
    chk("t3_dead_grant", o_grant, 0);
    chk("t3_dead_rdy", o_req_rdy, 0);
    cyc();
    chk("t3_grant3", o_grant, 4'b1000);
    chk("t3_rdy3", o_req_rdy, 4'b1000);
    cyc();
    drv(3, 0, 8'h00, 0); #1;

    // Backpressure on requester 0: tx_rdy 1,0,0,1.
    drv(0, 1, 8'h50, 0); push(0, 8'h50); #1;
    cyc();
    chk("t4_grant", o_grant, 4'b0001);
    cyc();
    drv(0, 1, 8'h51, 0); push(0, 8'h51); i_tx_rdy = 1'b0; #1;
    chk("t4_rdy_lo1", o_req_rdy, 0);
    chk("t4_data_lo1", o_tx_data, 8'h51);
    chk("t4_vld_lo1", o_tx_vld, 1);
    cyc();
    chk("t4_grant_lo2", o_grant, 4'b0001);
    chk("t4_data_lo2", o_tx_data, 8'h51);
    cyc();
    i_tx_rdy = 1'b1; #1;
    chk("t4_rdy_hi", o_req_rdy, 4'b0001);
    cyc();
    drv(0, 1, 8'h52, 1); push(0, 8'h52); #1;
    cyc();
    drv(0, 0, 8'h00, 0); #1;
    chk("t4_end_busy", o_busy, 0);
    cyc();

    // Timeout: owner 2 sends one byte then goes quiet; requester 0 waits.
    drv(2, 1, 8'h22, 0); push(2, 8'h22); #1;
    cyc();
    chk("t5_grant2", o_grant, 4'b0100);
    cyc();
    drv(2, 0, 8'h00, 0); drv(0, 1, 8'h0A, 1); push(0, 8'h0A); #1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold", o_grant, 4'b0100);
      chk("t5_rdy0_low", o_req_rdy[0], 0);
      cyc();
    end
    chk("t5_revoked", o_grant, 0);
    cyc();
    chk("t5_next_owner", o_grant, 4'b0001);
    cyc();
    drv(0, 0, 8'h00, 0); #1;

    // Reset in the middle of a message from requester 3.
    drv(3, 1, 8'h77, 0); push(3, 8'h77); #1;
    cyc();
    chk("t6_grant3", o_grant, 4'b1000);
    cyc();
    drv(3, 1, 8'h78, 0); i_tx_rdy = 1'b0; rst = 1'b1; #1;
    chk("t6_grant_in_rst", o_grant, 4'b1000);
    cyc();
    rst = 1'b0; i_tx_rdy = 1'b1; drv(3, 0, 8'h00, 0);
    drv(0, 1, 8'hE0, 1); drv(1, 1, 8'hE1, 1); push(0, 8'hE0); push(1, 8'hE1); #1;
    chk("t6_post_grant", o_grant, 0);
    chk("t6_post_busy", o_busy, 0);
    chk("t6_post_tx_vld", o_tx_vld, 0);
    chk("t6_post_rdy", o_req_rdy, 0);
    chk("t6_post_tx_data", o_tx_data, 0);
    cyc();
    chk("t6_from_zero", o_grant, 4'b0001);
    cyc();
    drv(0, 0, 8'h00, 0); #1;
    cyc();
    chk("t6_then_one", o_grant, 4'b0010);
    cyc();
    drv(1, 0, 8'h00, 0); #1;
    cyc();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
